// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub: valid/ready on both sides.
interface pipelined_add_sub_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// Segmented ripple adder/subtractor, SEG bits per stage; optional clamp via PIPELINED_ADD_SUB_SATURATE_EN.
// Latency WIDTH/SEG cycles from input transfer to out_valid; one op per cycle.
// Backpressure: whole pipe freezes while a result is held (in_ready = !(out_valid && !out_ready)).
module pipelined_add_sub #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_add_sub_if.slave bus
);
    localparam int L = WIDTH / SEG;

    // Stage k holds full operands, result segments [0..k-1] and the carry into segment k.
    logic [L-1:0]     vld;
    logic [L-1:0]     c_q;
    logic [WIDTH-1:0] a_q   [L];
    logic [WIDTH-1:0] b_q   [L];
    logic [WIDTH-1:0] s_q   [L];
    logic [SEG:0]     seg_sum [L];
    logic [WIDTH-1:0] s_nxt [L];

    logic             out_vld_q;
    logic [WIDTH-1:0] s_out_q;
    logic             cout_q;
    logic             ovf_q;

    logic             adv;
    logic             a_sign;
    logic             b_sign;
    logic             ovf_nxt;
    logic [WIDTH-1:0] res_nxt;

    assign adv          = !(out_vld_q && !bus.out_ready);
    assign bus.in_ready = adv;
    assign bus.out_valid = out_vld_q;
    assign bus.s        = s_out_q;
    assign bus.cout     = cout_q;
    assign bus.ovf      = ovf_q;

    for (genvar k = 0; k < L; k++) begin : g_seg
        assign seg_sum[k] = {1'b0, a_q[k][k*SEG +: SEG]}
                          + {1'b0, b_q[k][k*SEG +: SEG]}
                          + {{SEG{1'b0}}, c_q[k]};
    end

    always_comb begin
        for (int k = 0; k < L; k++) begin
            s_nxt[k] = s_q[k];
            s_nxt[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
        end
    end

    // b_q already carries the inverted operand in subtract mode.
    assign a_sign  = a_q[L-1][WIDTH-1];
    assign b_sign  = b_q[L-1][WIDTH-1];
    assign ovf_nxt = (a_sign == b_sign) && (s_nxt[L-1][WIDTH-1] != a_sign);

`ifdef PIPELINED_ADD_SUB_SATURATE_EN
    always_comb begin
        res_nxt = s_nxt[L-1];
        if (ovf_nxt) begin
            res_nxt = a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res_nxt = s_nxt[L-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= '0;
            out_vld_q <= 1'b0;
            s_out_q   <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (adv) begin
            vld[0] <= bus.in_valid;
            a_q[0] <= bus.a;
            b_q[0] <= bus.sub ? ~bus.b : bus.b;
            c_q[0] <= bus.sub ? 1'b1 : bus.cin;
            s_q[0] <= '0;
            for (int k = 1; k < L; k++) begin
                vld[k] <= vld[k-1];
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
                s_q[k] <= s_nxt[k-1];
                c_q[k] <= seg_sum[k-1][SEG];
            end
            out_vld_q <= vld[L-1];
            // Keep the last result on the port across bubbles.
            if (vld[L-1]) begin
                s_out_q <= res_nxt;
                cout_q  <= seg_sum[L-1][SEG];
                ovf_q   <= ovf_nxt;
            end
        end
    end
endmodule
